board_scorer: RTL and testbench

Avalon accelerator that consumes the candidate boards written by the per-piece move generators. It reads N consecutive 64-square boards from SDRAM and computes a material score for each. It returns to the CPU the index and score of the best board for the side to move. It shares the generators' slave/master port structure and the same board layout: 64 words per board, square (x,y) at word y*8+x, piece code as a signed byte in bits [7:0], positive = white, negative = black, 0 = empty.

---
 rtl/board_scorer.sv | 171 +++++++++++++++++
 tb/tb_board_scorer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_scorer.sv
// Scores N candidate boards read from SDRAM; reports index and material score of the best one for the side to move.
// Optional centre bonus is compiled in with CENTRE_BONUS_EN.
module board_scorer #(
  parameter int BOARD_WORDS = 64,
  parameter int MAX_BOARDS  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  typedef enum logic [2:0] {WAIT, ARGS, CHECK, RD_REQ, RD_WAIT, CMP, FINISH} state_t;

  state_t      state, state_nx;
  logic [31:0] src, num_boards, board, boards_scored;
  logic [31:0] best_idx, best_score, acc;
  logic [31:0] wr_data;
  logic [3:0]  wr_addr;
  logic [5:0]  sq;
  logic        side_neg;
  logic signed [31:0] sq_value, adj_acc, adj_best;
  logic        better;
  logic        unused_bits;

  assign unused_bits      = ^master_readdata[31:8];
  assign master_write     = 1'b0;
  assign master_writedata = 32'h0;

  function automatic logic signed [31:0] material(input logic [7:0] p);
    logic [7:0]         mag;
    logic signed [31:0] v;
    mag = p[7] ? (~p + 8'd1) : p;
    case (mag)
      8'd1:    v = 32'sd100;
      8'd2:    v = 32'sd320;
      8'd3:    v = 32'sd330;
      8'd4:    v = 32'sd500;
      8'd5:    v = 32'sd900;
      8'd6:    v = 32'sd20000;
      default: v = 32'sd0;
    endcase
    return p[7] ? -v : v;
  endfunction

`ifdef CENTRE_BONUS_EN
  // Non-king pieces on the four centre squares earn +10 for their owner.
  always_comb begin
    logic [7:0] mag;
    sq_value = material(master_readdata[7:0]);
    mag = master_readdata[7] ? (~master_readdata[7:0] + 8'd1) : master_readdata[7:0];
    if (mag >= 8'd1 && mag <= 8'd5 &&
        (sq == 6'd27 || sq == 6'd28 || sq == 6'd35 || sq == 6'd36))
      sq_value = master_readdata[7] ? sq_value - 32'sd10 : sq_value + 32'sd10;
  end
`else
  assign sq_value = material(master_readdata[7:0]);
`endif

  // Black maximises the negated score; an unset best always loses.
  assign adj_acc  = side_neg ? -$signed(acc) : $signed(acc);
  assign adj_best = side_neg ? -$signed(best_score) : $signed(best_score);
  assign better   = (best_idx == 32'hFFFF_FFFF) || (adj_acc > adj_best);

  always_comb begin
    state_nx          = state;
    slave_waitrequest = 1'b1;
    master_read       = 1'b0;
    master_address    = 32'h0;
    case (state)
      WAIT: begin
        slave_waitrequest = 1'b0;
        if (slave_write) state_nx = ARGS;
      end
      ARGS:  state_nx = (wr_addr == 4'd0) ? CHECK : WAIT;
      CHECK: state_nx = (board == num_boards) ? FINISH : RD_REQ;
      RD_REQ: begin
        master_read    = 1'b1;
        master_address = src + ((board * 32'(BOARD_WORDS) + 32'(sq)) << 2);
        if (!master_waitrequest) state_nx = RD_WAIT;
      end
      RD_WAIT: if (master_readdatavalid) state_nx = (sq == 6'd63) ? CMP : RD_REQ;
      CMP:     state_nx = CHECK;
      FINISH: begin
        slave_waitrequest = 1'b0;
        if (slave_read) state_nx = WAIT;
      end
      default: state_nx = WAIT;
    endcase
    // Reset takes the bus away immediately, not one edge later.
    if (!rst_n) begin
      slave_waitrequest = 1'b1;
      master_read       = 1'b0;
    end
  end

  always_comb begin
    slave_readdata = 32'h0;
    case (slave_address)
      4'd0:    slave_readdata = best_idx;
      4'd1:    slave_readdata = best_score;
      4'd2:    slave_readdata = boards_scored;
      default: slave_readdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= WAIT;
      src           <= 32'h0;
      num_boards    <= 32'h0;
      side_neg      <= 1'b0;
      board         <= 32'h0;
      boards_scored <= 32'h0;
      best_idx      <= 32'hFFFF_FFFF;
      best_score    <= 32'h8000_0000;
      acc           <= 32'h0;
      sq            <= 6'd0;
      wr_addr       <= 4'd0;
      wr_data       <= 32'h0;
    end else begin
      state <= state_nx;
      case (state)
        WAIT: if (slave_write) begin
          wr_addr <= slave_address;
          wr_data <= slave_writedata;
        end
        ARGS: case (wr_addr)
          4'd0: begin
            best_idx   <= 32'hFFFF_FFFF;
            best_score <= 32'h8000_0000;
            board      <= 32'h0;
            sq         <= 6'd0;
            acc        <= 32'h0;
          end
          4'd1: src <= wr_data;
          4'd2: num_boards <= (wr_data > 32'(MAX_BOARDS)) ? 32'(MAX_BOARDS) : wr_data;
          4'd3: side_neg <= wr_data[31];
          default: ;
        endcase
        RD_WAIT: if (master_readdatavalid) begin
          acc <= acc + sq_value;
          if (sq != 6'd63) sq <= sq + 6'd1;
        end
        CMP: begin
          if (better) begin
            best_idx   <= board;
            best_score <= acc;
          end
          board <= board + 32'h1;
          sq    <= 6'd0;
          acc   <= 32'h0;
        end
        FINISH: boards_scored <= board;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_scorer.sv
// Directed bench for board_scorer: SDRAM model with stalls/latency, scoring model, register readback checks.
module tb_board_scorer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = 4'd0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = 32'h0;
  logic        master_waitrequest = 1'b0;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata = 32'h0;
  logic        master_readdatavalid = 1'b0;
  logic        master_write;
  logic [31:0] master_writedata;

  int tests = 0;
  int fails = 0;
  logic [31:0] mem [0:4095];

  always #5 clk = ~clk;

  board_scorer dut (
    .clk(clk), .rst_n(rst_n),
    .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
    .slave_read(slave_read), .slave_readdata(slave_readdata),
    .slave_write(slave_write), .slave_writedata(slave_writedata),
    .master_waitrequest(master_waitrequest), .master_address(master_address),
    .master_read(master_read), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .master_write(master_write), .master_writedata(master_writedata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SDRAM model: stalls each new request, returns data 'lat' cycles after acceptance.
  int          stall_cycles = 0;
  int          lat = 1;
  int          stall_ctr = 0;
  bit          req_seen = 0;
  int          pend = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] req_addr = 32'h0;
  int          rd_count = 0;
  int          stable_err = 0;
  logic [31:0] exp_base = 32'h0;

  always @(negedge clk) begin
    master_readdatavalid = 1'b0;
    if (!rst_n) begin
      req_seen = 0;
      pend = 0;
      master_waitrequest = 1'b0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          master_readdatavalid = 1'b1;
          master_readdata = mem[pend_addr[13:2]];
        end
      end
      if (master_read) begin
        if (!req_seen) begin
          req_seen = 1;
          req_addr = master_address;
          stall_ctr = stall_cycles;
        end else if (master_address !== req_addr) begin
          stable_err++;
        end
        if (stall_ctr > 0) begin
          master_waitrequest = 1'b1;
          stall_ctr--;
        end else begin
          master_waitrequest = 1'b0;
          check("rd_addr", master_address, exp_base + 32'(4 * rd_count));
          check("master_write", {31'h0, master_write}, 32'h0);
          rd_count++;
          pend = lat;
          pend_addr = master_address;
        end
      end else begin
        if (req_seen && master_waitrequest) stable_err++;
        req_seen = 0;
        master_waitrequest = 1'b0;
      end
    end
  end

  function automatic int val(input logic [7:0] p, input int sq);
    int sp, mag, v;
    sp  = int'($signed(p));
    mag = (sp < 0) ? -sp : sp;
    case (mag)
      1: v = 100;  2: v = 320;  3: v = 330;
      4: v = 500;  5: v = 900;  6: v = 20000;
      default: v = 0;
    endcase
`ifdef CENTRE_BONUS_EN
    if (mag >= 1 && mag <= 5 && (sq == 27 || sq == 28 || sq == 35 || sq == 36)) v += 10;
`endif
    return (sp < 0) ? -v : v;
  endfunction

  task automatic model(input logic [31:0] src, input int n, input bit neg,
                       output logic [31:0] e_idx, output logic [31:0] e_score);
    int best, s;
    e_idx = 32'hFFFF_FFFF;
    e_score = 32'h8000_0000;
    best = 0;
    for (int b = 0; b < n; b++) begin
      s = 0;
      for (int q = 0; q < 64; q++) s += val(mem[((src >> 2) + b * 64 + q) & 4095][7:0], q);
      if (b == 0 || (neg ? (-s > -best) : (s > best))) begin
        best = s;
        e_idx = b;
        e_score = s;
      end
    end
  endtask

  task automatic put(input int base_word, input int sq, input int piece);
    mem[base_word + sq] = {8'hDE, 16'(base_word + sq), 8'(piece)};
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    int k = 0;
    while (slave_waitrequest && k < 100) begin @(negedge clk); k++; end
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    @(negedge clk);
    slave_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
    int k = 0;
    while (slave_waitrequest && k < 100) begin @(negedge clk); k++; end
    slave_address = a; slave_read = 1'b1;
    #1 d = slave_readdata;
    @(negedge clk);
    slave_read = 1'b0;
  endtask

  task automatic start(input logic [31:0] src, input int n, input logic [31:0] side,
                       input int st, input int lt);
    stall_cycles = st; lat = lt; exp_base = src; rd_count = 0; stable_err = 0;
    cpu_write(4'd1, src);
    cpu_write(4'd2, n);
    cpu_write(4'd3, side);
    cpu_write(4'd0, 32'd1);
  endtask

  task automatic run(input string name, input logic [31:0] src, input int n,
                     input logic [31:0] side, input int st, input int lt,
                     output logic [31:0] r_idx, output logic [31:0] r_score);
    logic [31:0] e_idx, e_score, r_cnt;
    int k = 0;
    start(src, n, side, st, lt);
    while (slave_waitrequest && k < 40000) begin @(negedge clk); k++; end
    check({name, "_done"}, {31'h0, slave_waitrequest}, 32'h0);
    cpu_read(4'd0, r_idx);
    cpu_read(4'd1, r_score);
    cpu_read(4'd2, r_cnt);
    model(src, n, side[31], e_idx, e_score);
    check({name, "_idx"}, r_idx, e_idx);
    check({name, "_score"}, r_score, e_score);
    check({name, "_count"}, r_cnt, 32'(n));
    check({name, "_reads"}, 32'(rd_count), 32'(n * 64));
    check({name, "_stable"}, 32'(stable_err), 32'h0);
  endtask

  initial begin
    logic [31:0] i0, s0, i1, s1, d;
    int pos [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    int k;

    for (int w = 0; w < 4096; w++) put(0, w, 0);
    // Board region 0x0000: initial chess position.
    for (int x = 0; x < 8; x++) begin
      put(0, x, pos[x]);       put(0, 8 + x, 1);
      put(0, 48 + x, -1);      put(0, 56 + x, -pos[x]);
    end
    // Region 0x1000: scores -100, +500, +500.
    for (int b = 0; b < 3; b++) begin put(1024 + b * 64, 4, 6); put(1024 + b * 64, 60, -6); end
    put(1024, 50, -1);
    put(1088, 0, 4);
    put(1152, 7, 4);
    // Region 0x2000: kings, white knight on 27, plus codes that must score nothing.
    put(2048, 4, 6); put(2048, 60, -6); put(2048, 27, 2);
    put(2048, 10, 7); put(2048, 11, -128);

    repeat (2) @(negedge clk);
    check("rst_waitreq", {31'h0, slave_waitrequest}, 32'h1);
    check("rst_mread", {31'h0, master_read}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_waitreq", {31'h0, slave_waitrequest}, 32'h0);
    check("idle_maddr", master_address, 32'h0);
    check("idle_mwdata", master_writedata, 32'h0);
    cpu_read(4'd0, d); check("idle_idx", d, 32'hFFFF_FFFF);
    cpu_read(4'd1, d); check("idle_score", d, 32'h8000_0000);
    cpu_read(4'd2, d); check("idle_count", d, 32'h0);
    cpu_read(4'd5, d); check("idle_addr5", d, 32'h0);

    run("init", 32'h0000, 1, 32'd1, 0, 1, i0, s0);
    check("init_lit_idx", i0, 32'h0);
    check("init_lit_score", s0, 32'h0);
    run("init_stall", 32'h0000, 1, 32'd1, 5, 2, i1, s1);
    check("stall_same_idx", i1, i0);
    check("stall_same_score", s1, s0);

    run("three_w", 32'h1000, 3, 32'd1, 0, 1, i0, s0);
    check("three_w_lit_idx", i0, 32'd1);
    check("three_w_lit_score", s0, 32'd500);
    run("three_b", 32'h1000, 3, 32'hFFFF_FFFF, 0, 3, i0, s0);
    check("three_b_lit_idx", i0, 32'd0);
    check("three_b_lit_score", s0, 32'hFFFF_FF9C);
    run("three_w_stall", 32'h1000, 3, 32'd1, 5, 1, i1, s1);
    check("three_stall_idx", i1, 32'd1);

    run("zero", 32'h3000, 0, 32'd1, 0, 1, i0, s0);
    check("zero_lit_idx", i0, 32'hFFFF_FFFF);
    check("zero_lit_score", s0, 32'h8000_0000);

    run("knight", 32'h2000, 1, 32'd1, 0, 1, i0, s0);
`ifdef CENTRE_BONUS_EN
    check("knight_lit", s0, 32'd330);
`else
    check("knight_lit", s0, 32'd320);
`endif

    // Reset while waiting for read data.
    start(32'h1000, 3, 32'd1, 0, 3);
    k = 0;
    while (!master_read && k < 100) begin @(negedge clk); k++; end
    check("mid_saw_read", {31'h0, master_read}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_mread", {31'h0, master_read}, 32'h0);
    check("mid_rst_waitreq", {31'h0, slave_waitrequest}, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_wait_waitreq", {31'h0, slave_waitrequest}, 32'h0);
    repeat (5) @(negedge clk);
    check("mid_no_read", {31'h0, master_read}, 32'h0);
    cpu_read(4'd0, d); check("mid_idx", d, 32'hFFFF_FFFF);
    cpu_read(4'd1, d); check("mid_score", d, 32'h8000_0000);

    // Reset while a stalled request is on the bus drops master_read at once.
    start(32'h1000, 3, 32'd1, 5, 1);
    k = 0;
    while (!master_read && k < 100) begin @(negedge clk); k++; end
    rst_n = 1'b0;
    #1 check("req_rst_mread", {31'h0, master_read}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cpu_read(4'd0, d); check("req_rst_idx", d, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
